// File: rtl/operand_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : operand_fetch                                                     |
// | Brief  : RV32 operand-fetch stage sharing one register-file port, with     |
// |          writeback priority and forwarding into captured operands.         |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module operand_fetch #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic [AW-1:0]   rf_addr,
  output logic            rf_write,
  output logic [XLEN-1:0] rf_wdata,
  input  logic [XLEN-1:0] rf_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [AW-1:0]   out_rd,
  output logic [XLEN-1:0] out_rs1_val,
  output logic [XLEN-1:0] out_rs2_val
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD1  = 2'd1,
    S_RD2  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          r_state;
  logic [31:0]     r_instr;
  logic [AW-1:0]   r_rd;
  logic [XLEN-1:0] r_rs1_val;
  logic [XLEN-1:0] r_rs2_val;
  logic            r_valid;

  logic [AW-1:0]   w_rs1;
  logic [AW-1:0]   w_rs2;
  logic            w_wr_en;
  logic            w_fwd_rs1;
  logic            w_fwd_rs2;
  logic [XLEN-1:0] w_rd_data;

  assign w_rs1   = AW'(r_instr[19:15]);
  assign w_rs2   = AW'(r_instr[24:20]);
  assign w_wr_en = wb_valid && (wb_addr != '0);

  // A real write to a captured source overrides the stale operand value.
  assign w_fwd_rs1 = w_wr_en && (w_rs1 == wb_addr);
  assign w_fwd_rs2 = w_wr_en && (w_rs2 == wb_addr);

  // x0 always reads as zero whatever the register file returns.
  assign w_rd_data = (rf_addr == '0) ? '0 : rf_rdata;

  always_comb begin
    rf_addr = '0;
    if (wb_valid) begin
      rf_addr = wb_addr;
    end else if (r_state == S_RD1) begin
      rf_addr = w_rs1;
    end else if (r_state == S_RD2) begin
      rf_addr = w_rs2;
    end
  end

  assign rf_write = rst_n && w_wr_en;
  assign rf_wdata = wb_valid ? wb_data : '0;
  assign in_ready = (r_state == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_instr   <= '0;
      r_rd      <= '0;
      r_rs1_val <= '0;
      r_rs2_val <= '0;
      r_valid   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_instr <= in_instr;
            r_rd    <= AW'(in_instr[11:7]);
            r_state <= S_RD1;
          end
        end
        S_RD1: begin
          if (!wb_valid) begin
            r_rs1_val <= w_rd_data;
            r_state   <= S_RD2;
          end
        end
        S_RD2: begin
          if (!wb_valid) begin
            r_rs2_val <= w_rd_data;
            r_valid   <= 1'b1;
            r_state   <= S_DONE;
          end else if (w_fwd_rs1) begin
            r_rs1_val <= wb_data;
          end
        end
        S_DONE: begin
          if (w_fwd_rs1) begin
            r_rs1_val <= wb_data;
          end
          if (w_fwd_rs2) begin
            r_rs2_val <= wb_data;
          end
          if (out_ready) begin
            r_valid <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_valid   = r_valid;
  assign out_instr   = r_instr;
  assign out_rd      = r_rd;
  assign out_rs1_val = r_rs1_val;
  assign out_rs2_val = r_rs2_val;

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_operand_fetch                                                  |
// | Brief  : Directed scoreboard bench for operand_fetch with a regfile model. |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [4:0]  rf_addr;
  logic        rf_write;
  logic [31:0] rf_wdata;
  logic [31:0] rf_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [4:0]  out_rd;
  logic [31:0] out_rs1_val;
  logic [31:0] out_rs2_val;

  operand_fetch #(.XLEN(32), .AW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .rf_addr(rf_addr), .rf_write(rf_write), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_rd(out_rd), .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val)
  );

  always #5 clk = ~clk;

  // Register file model; x0 holds junk so the stage's x0 zeroing is exercised.
  logic        tb_load;
  logic [31:0] mem [32];
  always_ff @(posedge clk) begin
    if (tb_load) begin
      for (int i = 0; i < 32; i++) mem[i] <= (i == 0) ? 32'hBAD0BAD0 : 32'h10000000 + 32'(i);
    end else if (rf_write) begin
      mem[rf_addr] <= rf_wdata;
    end
  end
  assign rf_rdata = mem[rf_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_rf [32];
  int          n_chk = 0;
  int          n_pass = 0;
  int          acc_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_wb(input logic [4:0] addr, input logic [31:0] data);
    wb_valid = 1'b1;
    wb_addr  = addr;
    wb_data  = data;
    #1;
    chk("wb_rf_addr", 32'(rf_addr), 32'(addr));
    chk("wb_rf_write", 32'(rf_write), 32'(addr != 5'd0));
    chk("wb_rf_wdata", rf_wdata, data);
    step();
    wb_valid = 1'b0;
    wb_addr  = '0;
    wb_data  = '0;
    if (addr != 5'd0) exp_rf[addr] = data;
  endtask

  task automatic issue(input logic [31:0] instr, input logic push,
                       input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < 20 && !in_ready; i++) step();
    chk("in_ready_before_issue", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_instr = instr;
    if (push) sb.push_back('{instr: instr, rd: instr[11:7], a: a, b: b});
    step();
    acc_cyc  = cyc;
    in_valid = 1'b0;
    in_instr = '0;
  endtask

  task automatic wait_out(input int exp_lat);
    for (int i = 0; i < 30 && !out_valid; i++) step();
    chk("out_valid_arrived", 32'(out_valid), 32'd1);
    chk("latency", 32'(cyc - acc_cyc), 32'(exp_lat));
  endtask

  task automatic check_out();
    exp_t e;
    chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("out_instr", out_instr, e.instr);
      chk("out_rd", 32'(out_rd), 32'(e.rd));
      chk("out_rs1_val", out_rs1_val, e.a);
      chk("out_rs2_val", out_rs2_val, e.b);
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("in_ready_after_release", 32'(in_ready), 32'd1);
    chk("out_valid_after_release", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) exp_rf[i] = (i == 0) ? 32'h0 : 32'h10000000 + 32'(i);
    rst_n = 1'b0; tb_load = 1'b1;
    in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
    wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'h77777777;
    step();
    step();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_rs1", out_rs1_val, 32'd0);
    chk("rst_rf_write_forced", 32'(rf_write), 32'd0);
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    tb_load = 1'b0; rst_n = 1'b1;
    step();

    // Preload and basic add x3,x1,x2
    do_wb(5'd1, 32'h11111111);
    do_wb(5'd2, 32'h22222222);
    issue(32'h002081B3, 1'b1, exp_rf[1], exp_rf[2]);
    chk("rd1_no_valid", 32'(out_valid), 32'd0);
    wait_out(2);
    check_out();
    release_out();

    // Writeback to x0 is dropped; x0 operands read as zero
    do_wb(5'd0, 32'hDEADBEEF);
    issue(32'h00000233, 1'b1, 32'h0, 32'h0);
    wait_out(2);
    check_out();
    release_out();

    // Three writeback cycles during RD1 stall the read; rs1 sees the last write
    issue(32'h00208333, 1'b1, 32'h33333333, exp_rf[2]);
    for (int k = 0; k < 3; k++) begin
      wb_valid = 1'b1;
      wb_addr  = (k == 0) ? 5'd9 : (k == 1) ? 5'd10 : 5'd1;
      wb_data  = (k == 0) ? 32'hA9A9A9A9 : (k == 1) ? 32'hA0A0A0A0 : 32'h33333333;
      #1;
      chk("stall_rf_addr", 32'(rf_addr), 32'(wb_addr));
      chk("stall_no_valid", 32'(out_valid), 32'd0);
      step();
      exp_rf[wb_addr] = wb_data;
    end
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    #1;
    chk("still_rd1_addr", 32'(rf_addr), 32'd1);
    wait_out(5);
    check_out();
    release_out();

    // Forwarding in DONE into both operands, then a long stall on out_ready
    issue(32'h005283B3, 1'b1, exp_rf[5], exp_rf[5]);
    wait_out(2);
    check_out();
    do_wb(5'd5, 32'hCAFEF00D);
    chk("fwd_done_rs1", out_rs1_val, 32'hCAFEF00D);
    chk("fwd_done_rs2", out_rs2_val, 32'hCAFEF00D);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_instr", out_instr, 32'h005283B3);
      chk("hold_rd", 32'(out_rd), 32'd7);
      chk("hold_rs1", out_rs1_val, 32'hCAFEF00D);
      chk("hold_rs2", out_rs2_val, 32'hCAFEF00D);
    end
    release_out();

    // Forwarding into rs1 while stalled in RD2
    issue(32'h00228433, 1'b1, 32'h12345678, exp_rf[2]);
    step();
    do_wb(5'd5, 32'h12345678);
    wait_out(3);
    check_out();
    release_out();

    // Asynchronous reset in RD2 discards the instruction
    issue(32'h002081B3, 1'b0, 32'h0, 32'h0);
    step();
    wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h5A5A5A5A;
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_rf_write", 32'(rf_write), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_instr", out_instr, 32'd0);
    chk("midrst_out_rs1", out_rs1_val, 32'd0);
    chk("midrst_out_rs2", out_rs2_val, 32'd0);
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    step();
    rst_n = 1'b1;
    step();
    issue(32'h002081B3, 1'b1, exp_rf[1], exp_rf[2]);
    wait_out(2);
    check_out();
    release_out();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
